camera_capture_param: RTL and testbench

Parametrised DVP (OV7670-style) camera capture front end, running entirely in the camera pixel-clock domain. It assembles 1 or 2 bytes per pixel into pixel words and tags each pixel with its x/y coordinate. Capture is either single-shot (arm request) or continuous, always starting on a clean frame boundary. Each completed frame is checked against the configured geometry, with a per-frame error flag. Output feeds the frame-buffer write logic downstream.

---
 rtl/camera_capture_param.sv | 112 +++++++++++
 tb/tb_camera_capture_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_param.sv
// camera_capture_param: DVP camera capture front end in the pixel-clock domain.
// Assembles 1 or 2 bytes per pixel, tags each pixel with x/y, checks frame geometry.
// Ports: p_clock_in/rst_in (async, active-high); vsync_in, href_in, p_data_in from the camera;
// arm_in (single shot), continuous_in; pixel_data/valid/x/y_out toward the frame buffer;
// frame_done_out/frame_error_out per captured frame; busy_out whenever not idle.
module camera_capture_param #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter int H_PIXELS = 320,
  parameter int V_LINES = 240,
  parameter int COORD_W = 10
) (
  input  logic                         p_clock_in,
  input  logic                         rst_in,
  input  logic                         vsync_in,
  input  logic                         href_in,
  input  logic [7:0]                   p_data_in,
  input  logic                         arm_in,
  input  logic                         continuous_in,
  output logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out,
  output logic                         pixel_valid_out,
  output logic [COORD_W-1:0]           pixel_x_out,
  output logic [COORD_W-1:0]           pixel_y_out,
  output logic                         frame_done_out,
  output logic                         frame_error_out,
  output logic                         busy_out
);
  typedef enum logic [1:0] {IDLE, SYNC, WAIT_START, CAPTURE} state_t;
  localparam logic [COORD_W-1:0] H_MAX = COORD_W'(H_PIXELS);
  localparam logic [COORD_W-1:0] V_MAX = COORD_W'(V_LINES);
  localparam logic PH_LAST = 1'(BYTES_PER_PIXEL - 1);
  state_t state, state_nxt;
  logic href_q, phase, err, ph, pix_last, capturing, line_end;
  logic [COORD_W-1:0] x, y;
  logic [8*BYTES_PER_PIXEL-1:0] pix;
  // vsync has priority: a byte arriving with vsync high is never processed
  assign capturing = state == CAPTURE && !vsync_in;
  assign ph = (href_in && !href_q) ? 1'b0 : phase;
  assign pix_last = ph == PH_LAST;
  assign line_end = capturing && !href_in && href_q;
  assign busy_out = state != IDLE;
  if (BYTES_PER_PIXEL == 2) begin : g_two
    logic [7:0] first_byte;
    always_ff @(posedge p_clock_in or posedge rst_in)
      if (rst_in) first_byte <= '0;
      else if (capturing && href_in && !pix_last) first_byte <= p_data_in;
    assign pix = MSB_FIRST ? {first_byte, p_data_in} : {p_data_in, first_byte};
  end else begin : g_one
    assign pix = p_data_in;
  end
  always_ff @(posedge p_clock_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = (arm_in || continuous_in) ? SYNC : IDLE;
      SYNC:       state_nxt = vsync_in ? WAIT_START : SYNC;
      WAIT_START: state_nxt = vsync_in ? WAIT_START : CAPTURE;
      default:    state_nxt = !vsync_in ? CAPTURE : continuous_in ? WAIT_START : IDLE;
    endcase
  end
  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) begin
      href_q <= 1'b0;
      phase <= 1'b0;
      err <= 1'b0;
      x <= '0;
      y <= '0;
      pixel_data_out <= '0;
      pixel_valid_out <= 1'b0;
      pixel_x_out <= '0;
      pixel_y_out <= '0;
      frame_done_out <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      href_q <= href_in;
      pixel_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      frame_error_out <= 1'b0;
      if (state == WAIT_START && !vsync_in) begin
        x <= '0;
        y <= '0;
        phase <= 1'b0;
        err <= 1'b0;
      end
      if (state == CAPTURE && vsync_in) begin
        frame_done_out <= 1'b1;
        frame_error_out <= err || y != V_MAX;
      end
      if (capturing && href_in) begin
        phase <= pix_last ? 1'b0 : ph + 1'b1;
        if (pix_last) begin
          if (x < H_MAX && y < V_MAX) begin
            pixel_valid_out <= 1'b1;
            pixel_data_out <= pix;
            pixel_x_out <= x;
            pixel_y_out <= y;
          end else err <= 1'b1;
          if (x != H_MAX) x <= x + 1'b1;
        end
      end
      // a short line, an over-long line or a dangling partial pixel all flag the frame
      if (line_end) begin
        if (x != H_MAX || phase) err <= 1'b1;
        x <= '0;
        phase <= 1'b0;
        if (y != V_MAX) y <= y + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_camera_capture_param.sv
// tb_camera_capture_param: DVP frames with random content against a frame-level model.
module tb_camera_capture_param;
  localparam int H = 4, V = 2, H1 = 8;
  logic clk = 0, rst = 1, vsync = 0, href = 0, arm = 0, cont = 0;
  logic [7:0] data = 0;
  logic [15:0] d0, d1;
  logic [7:0] d2;
  logic v0, v1, v2, dn0, dn1, dn2, fe0, fe1, fe2, b0, b1, b2;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  always #5 clk = ~clk;
  camera_capture_param #(.BYTES_PER_PIXEL(2), .MSB_FIRST(1), .H_PIXELS(H), .V_LINES(V), .COORD_W(10)) u0 (
    .p_clock_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .p_data_in(data), .arm_in(arm),
    .continuous_in(cont), .pixel_data_out(d0), .pixel_valid_out(v0), .pixel_x_out(x0), .pixel_y_out(y0),
    .frame_done_out(dn0), .frame_error_out(fe0), .busy_out(b0));
  camera_capture_param #(.BYTES_PER_PIXEL(2), .MSB_FIRST(0), .H_PIXELS(H), .V_LINES(V), .COORD_W(10)) u1 (
    .p_clock_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .p_data_in(data), .arm_in(arm),
    .continuous_in(cont), .pixel_data_out(d1), .pixel_valid_out(v1), .pixel_x_out(x1), .pixel_y_out(y1),
    .frame_done_out(dn1), .frame_error_out(fe1), .busy_out(b1));
  camera_capture_param #(.BYTES_PER_PIXEL(1), .MSB_FIRST(1), .H_PIXELS(H1), .V_LINES(V), .COORD_W(10)) u2 (
    .p_clock_in(clk), .rst_in(rst), .vsync_in(vsync), .href_in(href), .p_data_in(data), .arm_in(arm),
    .continuous_in(cont), .pixel_data_out(d2), .pixel_valid_out(v2), .pixel_x_out(x2), .pixel_y_out(y2),
    .frame_done_out(dn2), .frame_error_out(fe2), .busy_out(b2));
  typedef struct { int x; int y; logic [15:0] d; } pix_t;
  pix_t q2[$], q1[$];
  bit f2[$], f1[$];
  pix_t e;
  int r0, r1, r2, rf0, rf1, rf2, n_cmp, n_bad, n0, n2, nd0, lx0, ly0, mark_n, mark_d;
  bit got0, got1, got2;
  logic [15:0] fp0, fp1;
  logic [7:0] fp2;
  logic last_fe0;
  int len[4];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic extra(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got a strobe, expected none", nm);
  endtask
  always @(posedge clk) begin
    #2;
    if (v0) begin
      if (r0 < q2.size()) begin e = q2[r0]; chk("pix0", {x0, y0, d0}, {10'(e.x), 10'(e.y), e.d}); r0++; end
      else extra("pix0");
      if (!got0) fp0 = d0;
      got0 = 1; n0++; lx0 = x0; ly0 = y0;
    end
    if (v1) begin
      if (r1 < q2.size()) begin e = q2[r1]; chk("pix1", {x1, y1, d1}, {10'(e.x), 10'(e.y), e.d[7:0], e.d[15:8]}); r1++; end
      else extra("pix1");
      if (!got1) fp1 = d1;
      got1 = 1;
    end
    if (v2) begin
      if (r2 < q1.size()) begin e = q1[r2]; chk("pix2", {x2, y2, d2}, {10'(e.x), 10'(e.y), e.d[7:0]}); r2++; end
      else extra("pix2");
      if (!got2) fp2 = d2;
      got2 = 1; n2++;
    end
    if (dn0) begin
      if (rf0 < f2.size()) begin chk("ferr0", fe0, f2[rf0]); rf0++; end else extra("done0");
      nd0++; last_fe0 = fe0;
    end
    if (dn1) begin
      if (rf1 < f2.size()) begin chk("ferr1", fe1, f2[rf1]); rf1++; end else extra("done1");
    end
    if (dn2) begin
      if (rf2 < f1.size()) begin chk("ferr2", fe2, f1[rf2]); rf2++; end else extra("done2");
    end
  end
  // One frame: blanking, nl lines of len[l] bytes. A frame is captured iff a request is
  // present during its blanking; the expected pixels and error flag follow from line sizes.
  task automatic frame(int nl, bit pat, int arm_line, int drop_line, int rst_line);
    bit cap, ab, e2, e1;
    logic [7:0] b[16];
    pix_t p;
    vsync = 1; href = 0;
    cap = arm | cont;
    repeat (6) @(negedge clk);
    vsync = 0;
    repeat (2) @(negedge clk);
    arm = 0;
    repeat (2) @(negedge clk);
    ab = 0; e2 = nl != V; e1 = nl != V;
    for (int l = 0; l < nl; l++) begin
      if (l == arm_line) arm = 1;
      if (l == drop_line) cont = 0;
      for (int i = 0; i < len[l]; i++) b[i] = pat ? 8'(8'h12 + 8'h22 * i) : 8'($urandom);
      if (cap && !ab) begin
        e2 |= len[l] != 2 * H;
        e1 |= len[l] != H1;
        if (l < V) begin
          for (int i = 0; i < len[l] / 2 && i < H; i++) begin
            p.x = i; p.y = l; p.d = {b[2*i], b[2*i+1]}; q2.push_back(p);
          end
          for (int i = 0; i < len[l] && i < H1; i++) begin
            p.x = i; p.y = l; p.d = {8'h00, b[i]}; q1.push_back(p);
          end
        end
      end
      for (int i = 0; i < len[l]; i++) begin
        href = 1; data = b[i];
        if (l == rst_line && i == 3) begin
          rst = 1; ab = 1; r0 = q2.size(); r1 = r0; r2 = q1.size();
          #1;
          chk("rst_mid0", {v0, d0, x0, y0, dn0, fe0, b0}, 0);
          chk("rst_mid1", {v1, d1, x1, y1, dn1, fe1, b1}, 0);
          chk("rst_mid2", {v2, d2, x2, y2, dn2, fe2, b2}, 0);
        end
        @(negedge clk);
        rst = 0;
      end
      href = 0;
      repeat (2) @(negedge clk);
    end
    if (cap && !ab) begin f2.push_back(e2); f1.push_back(e1); end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst0", {v0, d0, x0, y0, dn0, fe0, b0}, 0);
    chk("rst1", {v1, d1, x1, y1, dn1, fe1, b1}, 0);
    chk("rst2", {v2, d2, x2, y2, dn2, fe2, b2}, 0);
    rst = 0;
    @(negedge clk);
    len = '{8, 8, 8, 8};
    arm = 1;
    frame(2, 1, -1, -1, -1);
    frame(2, 1, -1, -1, -1);
    chk("strobes0", n0, 8);
    chk("strobes2", n2, 16);
    chk("first0", fp0, 16'h1234);
    chk("first1", fp1, 16'h3412);
    chk("first2", fp2, 8'h12);
    chk("last_xy0", {lx0[9:0], ly0[9:0]}, {10'd3, 10'd1});
    chk("dones0", nd0, 1);
    chk("ferr_lit0", last_fe0, 0);
    chk("idle0", b0, 0);
    frame(2, 0, 1, -1, -1);
    chk("midarm_none", n0, 8);
    frame(2, 0, -1, -1, -1);
    chk("midarm_cap", n0, 16);
    arm = 1; len = '{10, 7, 8, 8};
    frame(2, 0, -1, -1, -1);
    len = '{8, 8, 8, 8};
    frame(2, 0, -1, -1, -1);
    chk("bad_geom_err", last_fe0, 1);
    chk("bad_geom_n", n0, 23);
    mark_n = n0; mark_d = nd0;
    cont = 1;
    repeat (3) frame(2, 0, -1, -1, -1);
    frame(2, 0, -1, 0, -1);
    frame(2, 0, -1, -1, -1);
    chk("cont_dones", nd0 - mark_d, 4);
    chk("cont_n", n0 - mark_n, 32);
    for (int k = 0; k < 24; k++) begin
      int nl, al, dl;
      nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 2;
      for (int l = 0; l < 4; l++) len[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 10)) : 8;
      al = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      arm = $urandom_range(0, 2) == 0;
      cont = 1'($urandom_range(0, 1));
      frame(nl, 0, al, dl, -1);
    end
    len = '{8, 8, 8, 8};
    arm = 1; cont = 0;
    frame(2, 0, -1, -1, 0);
    mark_d = nd0;
    frame(2, 0, -1, -1, -1);
    chk("rst_no_done", nd0, mark_d);
    chk("left_pix0", r0, q2.size());
    chk("left_pix1", r1, q2.size());
    chk("left_pix2", r2, q1.size());
    chk("left_f0", rf0, f2.size());
    chk("left_f1", rf1, f2.size());
    chk("left_f2", rf2, f1.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
